// File: rtl/data_bus_initiator.sv
// Single-outstanding initiator on the data_m bus: one valid/ready command in, one response out.
// Optional access timeout is enabled by defining BUS_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module data_bus_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [18:0] cmd_addr,
   input  logic        cmd_wr_en,
   input  logic [1:0]  cmd_bytesel,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic        busy,
   output logic [18:0] data_m_addr,
   output logic [15:0] data_m_data_out,
   input  logic [15:0] data_m_data_in,
   output logic        data_m_access,
   input  logic        data_m_ack,
   output logic        data_m_wr_en,
   output logic [1:0]  data_m_bytesel
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAccess = 2'd1;
   localparam logic [1:0] StResp   = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        busy_q, busy_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic [18:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        access_q, access_d;
   logic        wr_en_q, wr_en_d;
   logic [1:0]  bytesel_q, bytesel_d;
   logic        timeout_hit;
   logic [15:0] lane_mask;

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d       = cnt_q;
      timeout_hit = 1'b0;
      // Held at zero in IDLE so it is already clear on entry to ACCESS.
      if (state_q == StIdle) begin
         cnt_d = '0;
      end else if (state_q == StAccess && !data_m_ack) begin
         cnt_d       = cnt_q + CntW'(1);
         timeout_hit = (cnt_d == CntMax);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
`endif

   assign lane_mask = {{8{bytesel_q[1]}}, {8{bytesel_q[0]}}};

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      access_d    = access_q;
      wr_en_d     = wr_en_q;
      bytesel_d   = bytesel_q;

      case (state_q)
         StIdle: begin
            if (cmd_valid && cmd_ready_q) begin
               addr_d    = cmd_addr;
               wdata_d   = cmd_wdata;
               wr_en_d   = cmd_wr_en;
               bytesel_d = cmd_bytesel;
               access_d  = 1'b1;
               state_d   = StAccess;
            end
         end
         StAccess: begin
            // An ack in the cycle the timeout is reached takes priority.
            if (data_m_ack) begin
               rsp_data_d  = wr_en_q ? 16'h0000 : (data_m_data_in & lane_mask);
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               access_d    = 1'b0;
               wr_en_d     = 1'b0;
               bytesel_d   = 2'b00;
               state_d     = StResp;
            end else if (timeout_hit) begin
               rsp_data_d  = 16'hFFFF;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               access_d    = 1'b0;
               wr_en_d     = 1'b0;
               bytesel_d   = 2'b00;
               state_d     = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_data_d  = 16'h0000;
               rsp_err_d   = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      cmd_ready_d = (state_d == StIdle);
      busy_d      = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 16'h0000;
         rsp_err_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 16'h0000;
         access_q    <= 1'b0;
         wr_en_q     <= 1'b0;
         bytesel_q   <= 2'b00;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         access_q    <= access_d;
         wr_en_q     <= wr_en_d;
         bytesel_q   <= bytesel_d;
      end
   end

   assign cmd_ready       = cmd_ready_q;
   assign busy            = busy_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_data        = rsp_data_q;
   assign rsp_err         = rsp_err_q;
   assign data_m_addr     = addr_q;
   assign data_m_data_out = wdata_q;
   assign data_m_access   = access_q;
   assign data_m_wr_en    = wr_en_q;
   assign data_m_bytesel  = bytesel_q;

endmodule

// File: tb/tb_data_bus_initiator.sv
// Directed bench for data_bus_initiator; adds a timeout scenario when BUS_TIMEOUT_EN is defined.
module tb_data_bus_initiator;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [18:0] cmd_addr;
   logic        cmd_wr_en;
   logic [1:0]  cmd_bytesel;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        busy;
   logic [18:0] data_m_addr;
   logic [15:0] data_m_data_out;
   logic [15:0] data_m_data_in;
   logic        data_m_access;
   logic        data_m_ack;
   logic        data_m_wr_en;
   logic [1:0]  data_m_bytesel;

   int n_chk  = 0;
   int n_fail = 0;

   data_bus_initiator #(
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_addr        (cmd_addr),
      .cmd_wr_en       (cmd_wr_en),
      .cmd_bytesel     (cmd_bytesel),
      .cmd_wdata       (cmd_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .rsp_err         (rsp_err),
      .busy            (busy),
      .data_m_addr     (data_m_addr),
      .data_m_data_out (data_m_data_out),
      .data_m_data_in  (data_m_data_in),
      .data_m_access   (data_m_access),
      .data_m_ack      (data_m_ack),
      .data_m_wr_en    (data_m_wr_en),
      .data_m_bytesel  (data_m_bytesel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [18:0] a, input logic w, input logic [1:0] bs,
                       input logic [15:0] d);
      cmd_valid   = 1'b1;
      cmd_addr    = a;
      cmd_wr_en   = w;
      cmd_bytesel = bs;
      cmd_wdata   = d;
   endtask

   initial begin
      reset          = 1'b1;
      cmd_valid      = 1'b0;
      cmd_addr       = '0;
      cmd_wr_en      = 1'b0;
      cmd_bytesel    = 2'b00;
      cmd_wdata      = 16'h0000;
      rsp_ready      = 1'b0;
      data_m_data_in = 16'h0000;
      data_m_ack     = 1'b0;
      tick();
      tick();
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_access", 32'(data_m_access), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'h0);
      reset = 1'b0;
      tick();

      // Read 0x12344, bytesel 11, ack one cycle after access is seen
      send(19'h091A2, 1'b0, 2'b11, 16'h0000);
      tick();
      cmd_valid = 1'b0;
      cmd_addr  = 19'h7FFFF;
      check("rd_access", 32'(data_m_access), 32'd1);
      check("rd_addr", 32'(data_m_addr), 32'h091A2);
      check("rd_wr_en", 32'(data_m_wr_en), 32'd0);
      check("rd_bytesel", 32'(data_m_bytesel), 32'd3);
      check("rd_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rd_busy", 32'(busy), 32'd1);
      tick();
      check("rd_no_rsp_yet", 32'(rsp_valid), 32'd0);
      check("rd_access_held", 32'(data_m_access), 32'd1);
      data_m_ack     = 1'b1;
      data_m_data_in = 16'hBEEF;
      tick();
      data_m_ack     = 1'b0;
      data_m_data_in = 16'h0000;
      check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      check("rd_rsp_data", 32'(rsp_data), 32'hBEEF);
      check("rd_rsp_err", 32'(rsp_err), 32'd0);
      check("rd_access_drop", 32'(data_m_access), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rd_rsp_done", 32'(rsp_valid), 32'd0);
      check("rd_idle_ready", 32'(cmd_ready), 32'd1);
      check("rd_idle_busy", 32'(busy), 32'd0);

      // Write 0x00400, wdata A55A, bytesel 01, ack after 5 cycles
      send(19'h00200, 1'b1, 2'b01, 16'hA55A);
      tick();
      cmd_valid = 1'b0;
      cmd_wdata = 16'h1111;
      cmd_addr  = 19'h00001;
      for (int i = 0; i < 5; i++) begin
         check("wr_access", 32'(data_m_access), 32'd1);
         check("wr_wr_en", 32'(data_m_wr_en), 32'd1);
         check("wr_data_out", 32'(data_m_data_out), 32'hA55A);
         check("wr_addr", 32'(data_m_addr), 32'h00200);
         check("wr_bytesel", 32'(data_m_bytesel), 32'd1);
         if (i == 4) begin
            data_m_ack     = 1'b1;
            data_m_data_in = 16'hFFFF;
         end
         tick();
      end
      data_m_ack     = 1'b0;
      data_m_data_in = 16'h0000;
      check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
      check("wr_rsp_data", 32'(rsp_data), 32'h0000);
      check("wr_access_drop", 32'(data_m_access), 32'd0);
      check("wr_wr_en_drop", 32'(data_m_wr_en), 32'd0);
      check("wr_bytesel_drop", 32'(data_m_bytesel), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("wr_rsp_done", 32'(rsp_valid), 32'd0);

      // bytesel 00 passes through unchanged, read response is zero
      send(19'h00010, 1'b0, 2'b00, 16'h0000);
      tick();
      cmd_valid = 1'b0;
      check("bs0_access", 32'(data_m_access), 32'd1);
      check("bs0_bytesel", 32'(data_m_bytesel), 32'd0);
      data_m_ack     = 1'b1;
      data_m_data_in = 16'hFFFF;
      tick();
      data_m_ack = 1'b0;
      check("bs0_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bs0_rsp_data", 32'(rsp_data), 32'h0000);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Read bytesel 10, bus returns 1234
      send(19'h00020, 1'b0, 2'b10, 16'h0000);
      tick();
      data_m_ack     = 1'b1;
      data_m_data_in = 16'h1234;
      // Next command waits behind the unconsumed response
      send(19'h00055, 1'b1, 2'b11, 16'h5A5A);
      tick();
      data_m_data_in = 16'h0000;
      check("hi_rsp_data", 32'(rsp_data), 32'h1200);
      for (int i = 0; i < 10; i++) begin
         // Stray acks during RESP must be ignored
         data_m_ack = (i < 3);
         check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         check("hold_rsp_data", 32'(rsp_data), 32'h1200);
         check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         check("hold_no_access", 32'(data_m_access), 32'd0);
         tick();
      end
      data_m_ack = 1'b0;
      rsp_ready  = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("hold_rsp_done", 32'(rsp_valid), 32'd0);
      check("hold_ready_back", 32'(cmd_ready), 32'd1);
      check("hold_access_gap", 32'(data_m_access), 32'd0);
      // Ack while IDLE, coinciding with the accept
      data_m_ack = 1'b1;
      tick();
      data_m_ack = 1'b0;
      cmd_valid  = 1'b0;
      check("next_access", 32'(data_m_access), 32'd1);
      check("next_addr", 32'(data_m_addr), 32'h00055);
      check("next_data_out", 32'(data_m_data_out), 32'h5A5A);
      check("idle_ack_no_rsp", 32'(rsp_valid), 32'd0);

`ifdef BUS_TIMEOUT_EN
      tick();
      // Reset during ACCESS
      reset = 1'b1;
      #1;
`else
      // Without timeout the access waits indefinitely
      for (int i = 0; i < 20; i++) begin
         tick();
         check("wait_access", 32'(data_m_access), 32'd1);
         check("wait_no_rsp", 32'(rsp_valid), 32'd0);
      end
      reset = 1'b1;
      #1;
`endif
      check("mid_rst_access", 32'(data_m_access), 32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_wr_en", 32'(data_m_wr_en), 32'd0);
      check("mid_rst_addr", 32'(data_m_addr), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         data_m_ack = 1'b1;
         tick();
         check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
         check("post_rst_no_access", 32'(data_m_access), 32'd0);
      end
      data_m_ack = 1'b0;

`ifdef BUS_TIMEOUT_EN
      // Timeout 8: access high exactly 8 cycles, then error response
      send(19'h00033, 1'b0, 2'b11, 16'h0000);
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("to_access", 32'(data_m_access), 32'd1);
         check("to_no_rsp", 32'(rsp_valid), 32'd0);
         tick();
      end
      check("to_access_drop", 32'(data_m_access), 32'd0);
      check("to_rsp_valid", 32'(rsp_valid), 32'd1);
      check("to_rsp_err", 32'(rsp_err), 32'd1);
      check("to_rsp_data", 32'(rsp_data), 32'hFFFF);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      // Ack on the cycle the limit is reached wins
      send(19'h00034, 1'b0, 2'b01, 16'h0000);
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
      end
      data_m_ack     = 1'b1;
      data_m_data_in = 16'hABCD;
      tick();
      data_m_ack = 1'b0;
      check("to_ack_wins_valid", 32'(rsp_valid), 32'd1);
      check("to_ack_wins_err", 32'(rsp_err), 32'd0);
      check("to_ack_wins_data", 32'(rsp_data), 32'h00CD);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
